dmx12x48_buf: RTL and testbench

//   1:2 flit demultiplexer for the 48-bit link datapath, the splitting counterpart of the
//   2:1 flit selector. It accepts one flit per cycle on a single valid/ready input and

---
 rtl/dmx12x48_buf_if.sv | 31 +++
 rtl/dmx12x48_buf.sv | 89 ++++++++
 tb/tb_dmx12x48_buf.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmx12x48_buf_if.sv
// Bundle of the input flit channel and the two output channels of the 1:2 flit demultiplexer.
// master = flit source plus both consumers (the environment); slave = the demultiplexer.
interface dmx12x48_buf_if #(
   parameter int WIDTH = 48,
   parameter int DEPTH = 2
);
   localparam int AW = $clog2(DEPTH);

   logic             in_valid;
   logic             in_sel;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out0_valid;
   logic [WIDTH-1:0] out0_data;
   logic             out0_ready;
   logic             out1_valid;
   logic [WIDTH-1:0] out1_data;
   logic             out1_ready;
   logic [AW:0]      out0_count;
   logic [AW:0]      out1_count;

   modport master (
      output in_valid, in_sel, in_data, out0_ready, out1_ready,
      input  in_ready, out0_valid, out0_data, out1_valid, out1_data, out0_count, out1_count
   );

   modport slave (
      input  in_valid, in_sel, in_data, out0_ready, out1_ready,
      output in_ready, out0_valid, out0_data, out1_valid, out1_data, out0_count, out1_count
   );
endinterface

// File: rtl/dmx12x48_buf.sv
// 1:2 flit demultiplexer: one valid/ready input steered by in_sel into one of two
// small fall-through FIFOs, each drained by its own valid/ready output.
module dmx12x48_buf #(
   parameter int WIDTH = 48,
   parameter int DEPTH = 2,
   localparam int AW = $clog2(DEPTH)
) (
   input logic           clk,
   input logic           reset_n,
   dmx12x48_buf_if.slave bus
);

   localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

   // Handshake: a transfer happens on a rising edge where valid & ready are both 1.
   // in_ready depends only on in_sel and registered counts; out*_valid only on counts.
   logic [WIDTH-1:0] mem_q [2][DEPTH];
   logic [AW-1:0]    wr_ptr_q [2];
   logic [AW-1:0]    wr_ptr_d [2];
   logic [AW-1:0]    rd_ptr_q [2];
   logic [AW-1:0]    rd_ptr_d [2];
   logic [AW:0]      count_q [2];
   logic [AW:0]      count_d [2];

   logic [1:0] full;
   logic [1:0] valid;
   logic [1:0] push;
   logic [1:0] pop;
   logic       in_ready;

   always_comb begin
      full  = '0;
      valid = '0;
      for (int k = 0; k < 2; k++) begin
         full[k]  = (count_q[k] == CNT_FULL);
         valid[k] = (count_q[k] != '0);
      end
      in_ready = bus.in_sel ? !full[1] : !full[0];
      push[0]  = bus.in_valid & in_ready & !bus.in_sel;
      push[1]  = bus.in_valid & in_ready & bus.in_sel;
      pop[0]   = valid[0] & bus.out0_ready;
      pop[1]   = valid[1] & bus.out1_ready;
   end

   always_comb begin
      for (int k = 0; k < 2; k++) begin
         wr_ptr_d[k] = push[k] ? wr_ptr_q[k] + AW'(1) : wr_ptr_q[k];
         rd_ptr_d[k] = pop[k]  ? rd_ptr_q[k] + AW'(1) : rd_ptr_q[k];
         count_d[k]  = count_q[k];
         case ({push[k], pop[k]})
            2'b10:   count_d[k] = count_q[k] + (AW + 1)'(1);
            2'b01:   count_d[k] = count_q[k] - (AW + 1)'(1);
            default: count_d[k] = count_q[k];
         endcase
      end
   end

   // Storage is cleared too so out*_data reads 0 straight out of reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < 2; k++) begin
            wr_ptr_q[k] <= '0;
            rd_ptr_q[k] <= '0;
            count_q[k]  <= '0;
            for (int e = 0; e < DEPTH; e++) begin
               mem_q[k][e] <= '0;
            end
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            wr_ptr_q[k] <= wr_ptr_d[k];
            rd_ptr_q[k] <= rd_ptr_d[k];
            count_q[k]  <= count_d[k];
            if (push[k]) begin
               mem_q[k][wr_ptr_q[k]] <= bus.in_data;
            end
         end
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.out0_valid = valid[0];
   assign bus.out1_valid = valid[1];
   assign bus.out0_data  = mem_q[0][rd_ptr_q[0]];
   assign bus.out1_data  = mem_q[1][rd_ptr_q[1]];
   assign bus.out0_count = count_q[0];
   assign bus.out1_count = count_q[1];

endmodule

// File: tb/tb_dmx12x48_buf.sv
// Directed and randomised checks of the 1:2 flit demultiplexer with per-output FIFOs.
module tb_dmx12x48_buf;

   localparam int WIDTH = 48;
   localparam int DEPTH = 2;

   logic clk;
   logic reset_n;
   int   checks;
   int   failures;

   logic [WIDTH-1:0] exp0_q [$];
   logic [WIDTH-1:0] exp1_q [$];

   dmx12x48_buf_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   dmx12x48_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.in_valid   = 1'b0;
      bus.in_sel     = 1'b0;
      bus.in_data    = '0;
      bus.out0_ready = 1'b0;
      bus.out1_ready = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset_n = 1'b0;
      #17;
      checks++;
      if (bus.out0_valid !== 1'b0 || bus.out1_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_valid got=%b%b exp=00", bus.out1_valid, bus.out0_valid);
      end
      checks++;
      if (bus.out0_count !== 2'd0 || bus.out1_count !== 2'd0) begin
         failures++;
         $display("FAIL reset_count got0=%0d got1=%0d exp=0", bus.out0_count, bus.out1_count);
      end
      checks++;
      if (bus.out0_data !== 48'h0 || bus.out1_data !== 48'h0) begin
         failures++;
         $display("FAIL reset_data got0=%h got1=%h exp=0", bus.out0_data, bus.out1_data);
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
      end
      @(negedge clk);
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_single_push();
      bus.in_valid = 1'b1;
      bus.in_sel   = 1'b0;
      bus.in_data  = 48'h0000_0000_0001;
      step();
      bus.in_valid = 1'b0;
      #1;
      checks++;
      if (bus.out0_valid !== 1'b1 || bus.out0_data !== 48'h0000_0000_0001) begin
         failures++;
         $display("FAIL single_out0 got_v=%b got_d=%h exp_v=1 exp_d=000000000001",
                  bus.out0_valid, bus.out0_data);
      end
      checks++;
      if (bus.out1_valid !== 1'b0 || bus.out0_count !== 2'd1) begin
         failures++;
         $display("FAIL single_side got_v1=%b got_c0=%0d exp_v1=0 exp_c0=1",
                  bus.out1_valid, bus.out0_count);
      end
      bus.out0_ready = 1'b1;
      step();
      bus.out0_ready = 1'b0;
      checks++;
      if (bus.out0_valid !== 1'b0 || bus.out0_count !== 2'd0) begin
         failures++;
         $display("FAIL single_drain got_v=%b got_c=%0d exp_v=0 exp_c=0",
                  bus.out0_valid, bus.out0_count);
      end
   endtask

   task automatic test_fill();
      bus.out0_ready = 1'b0;
      bus.in_valid   = 1'b1;
      bus.in_sel     = 1'b0;
      bus.in_data    = 48'h0000_0000_00B0;
      step();
      bus.in_data    = 48'h0000_0000_00C0;
      step();
      bus.in_valid   = 1'b0;
      #1;
      checks++;
      if (bus.out0_count !== 2'd2 || bus.in_ready !== 1'b0) begin
         failures++;
         $display("FAIL fill_full got_c=%0d got_rdy=%b exp_c=2 exp_rdy=0",
                  bus.out0_count, bus.in_ready);
      end
      checks++;
      if (bus.out0_data !== 48'h0000_0000_00B0) begin
         failures++;
         $display("FAIL fill_head got=%h exp=0000000000b0", bus.out0_data);
      end
      bus.in_sel = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL fill_other_ready got=%b exp=1", bus.in_ready);
      end
   endtask

   task automatic test_full_pop();
      bus.in_valid   = 1'b1;
      bus.in_sel     = 1'b0;
      bus.in_data    = 48'h0000_0000_00E0;
      bus.out0_ready = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b0) begin
         failures++;
         $display("FAIL fullpop_ready_pre got=%b exp=0", bus.in_ready);
      end
      step();
      bus.out0_ready = 1'b0;
      #1;
      checks++;
      if (bus.out0_count !== 2'd1 || bus.out0_data !== 48'h0000_0000_00C0 || bus.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL fullpop_after got_c=%0d got_d=%h got_rdy=%b exp_c=1 exp_d=0000000000c0 exp_rdy=1",
                  bus.out0_count, bus.out0_data, bus.in_ready);
      end
      step();
      bus.in_valid = 1'b0;
      checks++;
      if (bus.out0_count !== 2'd2) begin
         failures++;
         $display("FAIL fullpop_accept got=%0d exp=2", bus.out0_count);
      end
      bus.out0_ready = 1'b1;
      step();
      checks++;
      if (bus.out0_data !== 48'h0000_0000_00E0 || bus.out0_count !== 2'd1) begin
         failures++;
         $display("FAIL fullpop_order got_d=%h got_c=%0d exp_d=0000000000e0 exp_c=1",
                  bus.out0_data, bus.out0_count);
      end
      step();
      bus.out0_ready = 1'b0;
      checks++;
      if (bus.out0_valid !== 1'b0) begin
         failures++;
         $display("FAIL fullpop_empty got=%b exp=0", bus.out0_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [WIDTH-1:0] d;
      bus.out0_ready = 1'b1;
      bus.out1_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         d = 48'hD000_0000_0000 + WIDTH'(i);
         bus.in_valid = 1'b1;
         bus.in_sel   = i[0];
         bus.in_data  = d;
         #1;
         checks++;
         if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready i=%0d got=%b exp=1", i, bus.in_ready);
         end
         step();
         checks++;
         if (i[0] == 1'b0) begin
            if (bus.out0_valid !== 1'b1 || bus.out0_data !== d || bus.out0_count !== 2'd1 ||
                bus.out1_count !== 2'd0) begin
               failures++;
               $display("FAIL b2b_out0 i=%0d got_d=%h got_c0=%0d got_c1=%0d exp_d=%h exp_c0=1 exp_c1=0",
                        i, bus.out0_data, bus.out0_count, bus.out1_count, d);
            end
         end else begin
            if (bus.out1_valid !== 1'b1 || bus.out1_data !== d || bus.out1_count !== 2'd1 ||
                bus.out0_count !== 2'd0) begin
               failures++;
               $display("FAIL b2b_out1 i=%0d got_d=%h got_c1=%0d got_c0=%0d exp_d=%h exp_c1=1 exp_c0=0",
                        i, bus.out1_data, bus.out1_count, bus.out0_count, d);
            end
         end
      end
      bus.in_valid = 1'b0;
      step();
      checks++;
      if (bus.out0_valid !== 1'b0 || bus.out1_valid !== 1'b0) begin
         failures++;
         $display("FAIL b2b_drain got=%b%b exp=00", bus.out1_valid, bus.out0_valid);
      end
   endtask

   task automatic test_random();
      logic             pend;
      logic             v;
      logic             s;
      logic [WIDTH-1:0] d;
      logic             mrdy;
      int               bad;
      pend = 1'b0;
      v    = 1'b0;
      s    = 1'b0;
      d    = '0;
      bad  = 0;
      exp0_q.delete();
      exp1_q.delete();
      for (int c = 0; c < 10000; c++) begin
         if (!pend) begin
            v = ($urandom_range(0, 3) != 0);
            s = 1'($urandom_range(0, 1));
            d = {16'($urandom), 32'($urandom)};
         end
         bus.in_valid   = v;
         bus.in_sel     = s;
         bus.in_data    = d;
         bus.out0_ready = ($urandom_range(0, 2) != 0);
         bus.out1_ready = ($urandom_range(0, 3) == 0);
         #1;
         mrdy = s ? (exp1_q.size() != DEPTH) : (exp0_q.size() != DEPTH);
         checks++;
         if (bus.in_ready !== mrdy || bus.out0_valid !== (exp0_q.size() != 0) ||
             bus.out1_valid !== (exp1_q.size() != 0)) begin
            failures++;
            if (bad++ < 10)
               $display("FAIL rand_flags c=%0d got_rdy=%b got_v=%b%b exp_rdy=%b exp_v=%b%b", c,
                        bus.in_ready, bus.out1_valid, bus.out0_valid, mrdy,
                        exp1_q.size() != 0, exp0_q.size() != 0);
         end
         if (exp0_q.size() != 0 && bus.out0_ready) begin
            checks++;
            if (bus.out0_data !== exp0_q[0]) begin
               failures++;
               if (bad++ < 10)
                  $display("FAIL rand_out0 c=%0d got=%h exp=%h", c, bus.out0_data, exp0_q[0]);
            end
            void'(exp0_q.pop_front());
         end
         if (exp1_q.size() != 0 && bus.out1_ready) begin
            checks++;
            if (bus.out1_data !== exp1_q[0]) begin
               failures++;
               if (bad++ < 10)
                  $display("FAIL rand_out1 c=%0d got=%h exp=%h", c, bus.out1_data, exp1_q[0]);
            end
            void'(exp1_q.pop_front());
         end
         if (v && mrdy) begin
            if (s) exp1_q.push_back(d);
            else   exp0_q.push_back(d);
            pend = 1'b0;
         end else begin
            pend = v;
         end
         step();
         checks++;
         if (int'(bus.out0_count) != exp0_q.size() || int'(bus.out1_count) != exp1_q.size() ||
             bus.out0_count > 2'(DEPTH) || bus.out1_count > 2'(DEPTH)) begin
            failures++;
            if (bad++ < 10)
               $display("FAIL rand_count c=%0d got0=%0d got1=%0d exp0=%0d exp1=%0d", c,
                        bus.out0_count, bus.out1_count, exp0_q.size(), exp1_q.size());
         end
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid_burst();
      idle_inputs();
      bus.in_valid = 1'b1;
      bus.in_sel   = 1'b0;
      bus.in_data  = 48'h0000_0000_0A00;
      step();
      step();
      bus.in_sel   = 1'b1;
      bus.in_data  = 48'h0000_0000_0A01;
      step();
      step();
      #1;
      checks++;
      if (bus.out0_count !== 2'd2 || bus.out1_count !== 2'd2) begin
         failures++;
         $display("FAIL midrst_prefill got0=%0d got1=%0d exp=2", bus.out0_count, bus.out1_count);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (bus.out0_valid !== 1'b0 || bus.out1_valid !== 1'b0 ||
          bus.out0_count !== 2'd0 || bus.out1_count !== 2'd0) begin
         failures++;
         $display("FAIL midrst_async got_v=%b%b got_c0=%0d got_c1=%0d exp=0",
                  bus.out1_valid, bus.out0_valid, bus.out0_count, bus.out1_count);
      end
      bus.in_valid = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      step();
      bus.in_valid = 1'b1;
      bus.in_sel   = 1'b0;
      bus.in_data  = 48'h0000_0000_0F00;
      step();
      bus.in_valid = 1'b0;
      checks++;
      if (bus.out0_valid !== 1'b1 || bus.out0_data !== 48'h0000_0000_0F00 || bus.out0_count !== 2'd1) begin
         failures++;
         $display("FAIL midrst_after got_v=%b got_d=%h got_c=%0d exp_v=1 exp_d=000000000f00 exp_c=1",
                  bus.out0_valid, bus.out0_data, bus.out0_count);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset_n  = 1'b0;
      idle_inputs();
      test_reset();
      test_single_push();
      test_fill();
      test_full_pop();
      test_back_to_back();
      test_random();
      test_reset_mid_burst();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
